// File: rtl/shift_add_mult_8.sv
// Iterative 8x8 unsigned shift-and-add multiplier.
// One cla_16 adds the shifted multiplicand into the running sum.
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    gg = '0;
    gp = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
  end

  // second-level lookahead across the four nibble groups
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0])
          | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1])
          | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2])
          | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1]
               | (p[4*i+1] & g[4*i])
               | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2]
               | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

module shift_add_mult_8 #(
  parameter int EARLY_TERM = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  count;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] acc_next;
  logic        last;

  cla_16 u_cla (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // cout stays 0 while busy: acc is always below the current mcand
  assign acc_next = mplier[0] ? sum : acc;
  assign last = (count == 3'd7)
              | ((EARLY_TERM != 0) & (mplier[7:1] == 7'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= {8'h00, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= BUSY;
          end else begin
            state  <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= {mcand[14:0], 1'b0};
          mplier <= {1'b0, mplier[7:1]};
          count  <= count + 3'd1;
          if (last) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult_8.sv
// Bench for shift_add_mult_8: one instance per EARLY_TERM
// setting, checked against plain a*b and a latency rule.
module tb_shift_add_mult_8;

  logic        clk;
  logic        rst_n;
  logic        start   [2];
  logic [7:0]  ain     [2];
  logic [7:0]  bin     [2];
  logic        busy    [2];
  logic        done    [2];
  logic [15:0] product [2];
  logic [15:0] last    [2];

  int total = 0;
  int bad   = 0;

  shift_add_mult_8 #(.EARLY_TERM(0)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start[0]),
    .a       (ain[0]),
    .b       (bin[0]),
    .busy    (busy[0]),
    .done    (done[0]),
    .product (product[0])
  );

  shift_add_mult_8 #(.EARLY_TERM(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start[1]),
    .a       (ain[1]),
    .b       (bin[1]),
    .busy    (busy[1]),
    .done    (done[1]),
    .product (product[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && busy[0]) chk("cout0", {31'd0, u_dut0.u_cla.cout}, 0);
    if (rst_n && busy[1]) chk("cout1", {31'd0, u_dut1.u_cla.cout}, 0);
  end

  function automatic int lat(input int d, input logic [7:0] b);
    if (d == 0) return 8;
    if (b == 8'd0) return 1;
    return $clog2(int'(b) + 1);
  endfunction

  task automatic launch(input int d,
                        input logic [7:0] a,
                        input logic [7:0] b);
    start[d] = 1'b1;
    ain[d]   = a;
    bin[d]   = b;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    ain[d]   = 8'($urandom);
    bin[d]   = 8'($urandom);
  endtask

  // called #1 after the accepting edge; returns #1 after done edge
  task automatic wait_done(input int d,
                           input logic [7:0] a,
                           input logic [7:0] b,
                           input int poke,
                           input bit pulse);
    logic [15:0] want;
    int n, bcnt, steps;
    bit seen;
    want  = 16'(int'(a) * int'(b));
    n     = lat(d, b);
    bcnt  = 0;
    steps = 0;
    seen  = 0;
    chk("busy_after_start", {31'd0, busy[d]}, 1);
    if (busy[d]) bcnt++;
    for (int i = 1; i <= 20; i++) begin
      if (i == poke) begin
        start[d] = 1'b1;
        ain[d]   = 8'd1;
        bin[d]   = 8'd1;
      end else begin
        start[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done[d]) begin
        seen  = 1;
        steps = i;
        break;
      end
      if (busy[d]) bcnt++;
      chk("no_partial", {16'd0, product[d]}, {16'd0, last[d]});
    end
    start[d] = 1'b0;
    chk("done_seen", {31'd0, seen}, 1);
    chk("latency", steps, n);
    chk("busy_cycles", bcnt, n);
    chk("product", {16'd0, product[d]}, {16'd0, want});
    chk("busy_on_done", {31'd0, busy[d]}, 0);
    last[d] = want;
    if (pulse) begin
      @(posedge clk);
      #1;
      chk("done_width", {31'd0, done[d]}, 0);
      chk("held", {16'd0, product[d]}, {16'd0, want});
    end
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", {31'd0, busy[d]}, 0);
      chk("rst_done", {31'd0, done[d]}, 0);
      chk("rst_product", {16'd0, product[d]}, 0);
      last[d] = 16'd0;
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    int dn;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      ain[d]   = 8'd0;
      bin[d]   = 8'd0;
      last[d]  = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(0, 8'hFF, 8'hFF);
    wait_done(0, 8'hFF, 8'hFF, 0, 1);
    launch(0, 8'h12, 8'h34);
    wait_done(0, 8'h12, 8'h34, 0, 1);

    launch(1, 8'hA7, 8'h00);
    wait_done(1, 8'hA7, 8'h00, 0, 1);
    launch(1, 8'h33, 8'h03);
    wait_done(1, 8'h33, 8'h03, 0, 1);
    launch(1, 8'h05, 8'h03);
    wait_done(1, 8'h05, 8'h03, 0, 1);
    launch(1, 8'hFF, 8'hFF);
    wait_done(1, 8'hFF, 8'hFF, 0, 1);

    launch(0, 8'h10, 8'h10);
    wait_done(0, 8'h10, 8'h10, 3, 0);
    launch(0, 8'h02, 8'h03);
    wait_done(0, 8'h02, 8'h03, 0, 1);

    launch(1, 8'h10, 8'h10);
    wait_done(1, 8'h10, 8'h10, 2, 0);
    launch(1, 8'h02, 8'h03);
    wait_done(1, 8'h02, 8'h03, 0, 1);

    launch(0, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done[0] || done[1]) dn++;
    end
    chk("no_done_after_abort", dn, 0);

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k % 8 == 0) rb = 8'($urandom_range(0, 7));
      launch(k % 2, ra, rb);
      wait_done(k % 2, ra, rb, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
